// File: rtl/truth_table_scanner.sv
// -----------------------------------------------------------------------------
// truth_table_scanner
//
// Sequential reader for a combinational boolean function under test (FUT).
// It drives every input combination onto the FUT in ascending order, holds
// each vector for SETTLE_CYCLES cycles, samples the FUT output, and builds
// the complete truth table plus the minterm count. A start/done handshake
// frames each scan.
//
// Optional feature (compile-time macro TT_COMPARE_EN):
//   Adds a golden-table input and match / mismatch_mask outputs that compare
//   the captured table against the golden table at the end of the scan.
//   With the macro undefined these ports and their logic do not exist.
//
// Parameters:
//   N_INPUTS      number of FUT inputs (1..6); table depth is 2**N_INPUTS
//   SETTLE_CYCLES cycles each vector is held before f_in is sampled (>= 1)
//
// Ports:
//   clk           system clock, all state updates on the rising edge
//   rst_n         asynchronous active-low reset
//   start         scan request, accepted only while idle
//   f_in          FUT output, treated as synchronous to clk
//   vars_out      vector driven to the FUT (MSB = variable A)
//   busy          high while a scan is in progress
//   done          one-cycle pulse when the scan has completed
//   table_out     bit i = f_in sampled while vars_out == i
//   ones_count    number of 1 bits in table_out
//   expected_tt   (TT_COMPARE_EN) golden table, sampled at start acceptance
//   match         (TT_COMPARE_EN) 1 iff table_out == expected_tt
//   mismatch_mask (TT_COMPARE_EN) table_out XOR expected_tt
// -----------------------------------------------------------------------------
module truth_table_scanner #(
  parameter int N_INPUTS      = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      f_in,
`ifdef TT_COMPARE_EN
  input  logic [(1<<N_INPUTS)-1:0]  expected_tt,
  output logic                      match,
  output logic [(1<<N_INPUTS)-1:0]  mismatch_mask,
`endif
  output logic [N_INPUTS-1:0]       vars_out,
  output logic                      busy,
  output logic                      done,
  output logic [(1<<N_INPUTS)-1:0]  table_out,
  output logic [N_INPUTS:0]         ones_count
);

  localparam int DEPTH = 1 << N_INPUTS;
  // The settle counter only needs to hold SETTLE_CYCLES; keep at least 1 bit.
  localparam int CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

  localparam logic [N_INPUTS-1:0] LAST_IDX    = '1;
  localparam logic [CNT_W-1:0]    SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_e;

  state_e               state_q;
  logic [N_INPUTS-1:0]  idx_q;     // also the vector driven to the FUT
  logic [CNT_W-1:0]     cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic [DEPTH-1:0]     table_q;
  logic [N_INPUTS:0]    ones_q;

`ifdef TT_COMPARE_EN
  logic [DEPTH-1:0]     exp_q;
  logic                 match_q;
  logic [DEPTH-1:0]     mask_q;
`endif

  // NOTE: every register below, including the truth-table vector, is a plain
  // flop array rather than a RAM, so it is cleared by the asynchronous reset;
  // a reset mid-scan therefore leaves no partial results behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      table_q <= '0;
      ones_q  <= '0;
`ifdef TT_COMPARE_EN
      exp_q   <= '0;
      match_q <= 1'b0;
      mask_q  <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge register values regardless of statement order.
      done_q <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          // Results stay untouched until a new scan is actually accepted.
          if (start) begin
            idx_q   <= '0;
            table_q <= '0;
            ones_q  <= '0;
            cnt_q   <= SETTLE_LOAD;
            busy_q  <= 1'b1;
            state_q <= S_SETTLE;
`ifdef TT_COMPARE_EN
            exp_q   <= expected_tt;
            match_q <= 1'b0;
            mask_q  <= '0;
`endif
          end
        end

        S_SETTLE: begin
          // Counter starts at SETTLE_CYCLES, so this state lasts exactly
          // SETTLE_CYCLES cycles before the sample cycle.
          if (cnt_q == CNT_ONE) begin
            state_q <= S_SAMPLE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        S_SAMPLE: begin
          table_q[idx_q] <= f_in;
          ones_q         <= ones_q + (N_INPUTS+1)'(f_in);
          // The index never wraps: the last vector ends the scan and stays
          // on vars_out until the next accepted start.
          if (idx_q == LAST_IDX) begin
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            idx_q   <= idx_q + 1'b1;
            cnt_q   <= SETTLE_LOAD;
            state_q <= S_SETTLE;
          end
        end

        S_DONE: begin
          // start is deliberately ignored here; a held start is taken in the
          // following idle cycle.
          done_q  <= 1'b1;
          state_q <= S_IDLE;
`ifdef TT_COMPARE_EN
          match_q <= (table_q == exp_q);
          mask_q  <= table_q ^ exp_q;
`endif
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign vars_out   = idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign table_out  = table_q;
  assign ones_count = ones_q;

`ifdef TT_COMPARE_EN
  assign match         = match_q;
  assign mismatch_mask = mask_q;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// -----------------------------------------------------------------------------
// tb_truth_table_scanner
//
// Two scanner instances share clock and reset: instance 0 uses the default
// settle time (1 cycle), instance 1 uses a 3-cycle settle time. Each FUT is a
// behavioural function of vars_out selected by a mode variable. A reference
// model derives the expected truth table, minterm count and done cycle from
// the FUT definition and the timing rules; expectations are queued at start
// and a monitor pops and compares them whenever done is seen. The monitor also
// checks busy and the stepping of vars_out every cycle.
// Define TT_COMPARE_EN to also exercise the golden-table comparison outputs.
// -----------------------------------------------------------------------------
module tb_truth_table_scanner;

  typedef struct {
    logic [15:0] tt;
    logic [4:0]  ones;
    longint      done_cyc;
    logic        match;
    logic [15:0] mask;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start  [2];
  logic        f_in   [2];
  logic [3:0]  vars   [2];
  logic        busy   [2];
  logic        done   [2];
  logic [15:0] tt     [2];
  logic [4:0]  ones   [2];
  logic [15:0] exp_tt [2];
`ifdef TT_COMPARE_EN
  logic        match  [2];
  logic [15:0] mask   [2];
`endif

  int          mode    [2];
  logic [15:0] rtt     [2];
  longint      acc_cyc [2];
  longint      cyc = 0;

  exp_t sb0[$];
  exp_t sb1[$];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- model --
  function automatic int settle(int g);
    return (g == 0) ? 1 : 3;
  endfunction

  // Function under test: 0 = const 0, 1 = variable A, 2 = XOR of all inputs,
  // 3 = const 1, otherwise an arbitrary truth table r.
  function automatic logic fut(int m, logic [15:0] r, logic [3:0] v);
    case (m)
      0:       return 1'b0;
      1:       return v[3];
      2:       return ^v;
      3:       return 1'b1;
      default: return r[v];
    endcase
  endfunction

  function automatic logic [15:0] tt_of(int m, logic [15:0] r);
    logic [15:0] t;
    for (int i = 0; i < 16; i++) t[i] = fut(m, r, 4'(i));
    return t;
  endfunction

  function automatic exp_t model(int g, int m, logic [15:0] r, logic [15:0] e, longint k);
    exp_t x;
    x.tt       = tt_of(m, r);
    x.ones     = 5'($countones(x.tt));
    x.done_cyc = k + 16 * (settle(g) + 1) + 1;
    x.match    = (x.tt == e);
    x.mask     = x.tt ^ e;
    return x;
  endfunction

  // ------------------------------------------------------------------ DUT --
  for (genvar g = 0; g < 2; g++) begin : g_dut
    truth_table_scanner #(
      .N_INPUTS      (4),
      .SETTLE_CYCLES (g == 0 ? 1 : 3)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start[g]),
      .f_in          (f_in[g]),
`ifdef TT_COMPARE_EN
      .expected_tt   (exp_tt[g]),
      .match         (match[g]),
      .mismatch_mask (mask[g]),
`endif
      .vars_out      (vars[g]),
      .busy          (busy[g]),
      .done          (done[g]),
      .table_out     (tt[g]),
      .ones_count    (ones[g])
    );
    assign f_in[g] = fut(mode[g], rtt[g], vars[g]);
  end

  // -------------------------------------------------------------- helpers --
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(int g, exp_t x);
    if (g == 0) sb0.push_back(x);
    else        sb1.push_back(x);
  endtask

  task automatic wait_until(longint c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_done(int g);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = done[g];
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL timeout%0d: done not seen within 400 cycles", g);
    end
  endtask

  task automatic run_scan(int g, int m, logic [15:0] r, logic [15:0] e);
    longint k;
    @(negedge clk);
    mode[g]   = m;
    rtt[g]    = r;
    exp_tt[g] = e;
    start[g]  = 1'b1;
    k         = cyc + 1;
    push(g, model(g, m, r, e, k));
    acc_cyc[g] = k;
    @(negedge clk);
    start[g]  = 1'b0;
    exp_tt[g] = ~e;  // must not matter: golden table is sampled at acceptance
    wait_done(g);
  endtask

  task automatic check_zero(int g, string tag);
    check($sformatf("%s_vars%0d", tag, g), 64'(vars[g]), 64'(0));
    check($sformatf("%s_busy%0d", tag, g), 64'(busy[g]), 64'(0));
    check($sformatf("%s_done%0d", tag, g), 64'(done[g]), 64'(0));
    check($sformatf("%s_tt%0d",   tag, g), 64'(tt[g]),   64'(0));
    check($sformatf("%s_ones%0d", tag, g), 64'(ones[g]), 64'(0));
`ifdef TT_COMPARE_EN
    check($sformatf("%s_match%0d", tag, g), 64'(match[g]), 64'(0));
    check($sformatf("%s_mask%0d",  tag, g), 64'(mask[g]),  64'(0));
`endif
  endtask

  // Constant-1 FUT, start re-pulsed while busy, then start held through done.
  task automatic held_start_test();
    longint k;
    @(negedge clk);
    mode[0]  = 3;
    exp_tt[0] = 16'hFFFF;
    start[0] = 1'b1;
    k        = cyc + 1;
    push(0, model(0, 3, 16'h0, 16'hFFFF, k));
    acc_cyc[0] = k;
    @(negedge clk); start[0] = 1'b0;
    wait_until(k + 4);  start[0] = 1'b1;   // seen at edge k+5
    @(negedge clk);     start[0] = 1'b0;
    wait_until(k + 19); start[0] = 1'b1;   // seen at edge k+20
    @(negedge clk);     start[0] = 1'b0;
    wait_until(k + 32); start[0] = 1'b1;   // held through the done pulse
    @(negedge clk);                        // done visible now
    push(0, model(0, 3, 16'h0, 16'hFFFF, k + 34));
    acc_cyc[0] = k + 34;
    @(negedge clk);                        // after acceptance edge k+34
    check("held_accept_tt",   64'(tt[0]),   64'(0));
    check("held_accept_ones", 64'(ones[0]), 64'(0));
    start[0] = 1'b0;
    wait_done(0);
  endtask

  // Asynchronous reset between edges while the scan sits at index 7.
  task automatic reset_test();
    longint k;
    bit hit = 1'b0;
    @(negedge clk);
    mode[0]  = 3;
    start[0] = 1'b1;
    k        = cyc + 1;
    push(0, model(0, 3, 16'h0, exp_tt[0], k));
    acc_cyc[0] = k;
    @(negedge clk); start[0] = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      hit = (vars[0] == 4'd7);
    end
    if (!hit) begin
      checks++;
      failures++;
      $display("FAIL rst_reach: vars_out never reached 7");
    end
    check("pre_rst_tt", 64'(tt[0]), 64'(16'h007F));
    #2 rst_n = 1'b0;
    #1 check_zero(0, "midscan_rst");
    sb0.delete();
    acc_cyc[0] = -1000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // -------------------------------------------------------------- monitor --
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int g = 0; g < 2; g++) begin
        int     per;
        int     sz;
        longint a;
        longint step;
        exp_t   x;
        per = 16 * (settle(g) + 1);
        a   = acc_cyc[g];
        check($sformatf("busy%0d", g), 64'(busy[g]), 64'(cyc >= a && cyc < a + per));
        if (cyc >= a && cyc <= a + per) begin
          step = (cyc - a) / (settle(g) + 1);
          if (step > 15) step = 15;
          check($sformatf("vars%0d", g), 64'(vars[g]), 64'(step));
        end
        sz = (g == 0) ? sb0.size() : sb1.size();
        if (done[g]) begin
          if (sz == 0) begin
            checks++;
            failures++;
            $display("FAIL done%0d: unexpected pulse at cycle %0d", g, cyc);
          end else begin
            if (g == 0) x = sb0.pop_front();
            else        x = sb1.pop_front();
            check($sformatf("table%0d", g),   64'(tt[g]),   64'(x.tt));
            check($sformatf("ones%0d", g),    64'(ones[g]), 64'(x.ones));
            check($sformatf("done_cyc%0d", g), 64'(cyc),    64'(x.done_cyc));
`ifdef TT_COMPARE_EN
            check($sformatf("match%0d", g), 64'(match[g]), 64'(x.match));
            check($sformatf("mask%0d", g),  64'(mask[g]),  64'(x.mask));
`endif
          end
        end else if (sz > 0) begin
          if (g == 0) x = sb0[0];
          else        x = sb1[0];
          if (cyc > x.done_cyc) begin
            checks++;
            failures++;
            $display("FAIL done%0d: missing, expected at cycle %0d, now %0d", g, x.done_cyc, cyc);
            if (g == 0) void'(sb0.pop_front());
            else        void'(sb1.pop_front());
          end
        end
      end
    end
  end

  // ------------------------------------------------------------- stimulus --
  initial begin
    rst_n = 1'b1;
    for (int g = 0; g < 2; g++) begin
      start[g]   = 1'b0;
      mode[g]    = 0;
      rtt[g]     = '0;
      exp_tt[g]  = '0;
      acc_cyc[g] = -1000;
    end
    #1 rst_n = 1'b0;
    #1 begin
      check_zero(0, "por");
      check_zero(1, "por");
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_scan(0, 0, 16'h0, 16'h0000);       // f = 0
    run_scan(0, 1, 16'h0, 16'hFF00);       // f = A
    fork                                   // f = XOR on both settle times
      run_scan(1, 2, 16'h0, 16'h6996);
      run_scan(0, 2, 16'h0, 16'h6997);
    join
    run_scan(1, 2, 16'h0, 16'h6997);
    held_start_test();
    reset_test();
    run_scan(0, 4, 16'($urandom), 16'h0);  // clean scan after reset

    for (int it = 0; it < 6; it++) begin
      int          m0, m1;
      logic [15:0] r0, r1, e0, e1;
      m0 = $urandom_range(0, 4);
      m1 = $urandom_range(0, 4);
      r0 = 16'($urandom);
      r1 = 16'($urandom);
      e0 = ($urandom_range(0, 1) == 1) ? tt_of(m0, r0) : 16'($urandom);
      e1 = ($urandom_range(0, 1) == 1) ? tt_of(m1, r1) : 16'($urandom);
      fork
        run_scan(0, m0, r0, e0);
        run_scan(1, m1, r1, e1);
      join
    end

    repeat (5) @(negedge clk);
    if (sb0.size() != 0 || sb1.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL leftover: %0d/%0d expectations never matched", sb0.size(), sb1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/truth_table_scanner.md
Name: truth_table_scanner

Overview:
- Sequential reader for the combinational boolean-function blocks: drives every input combination onto a function under test (FUT) and samples its single output `f`.
- Captures the complete truth table plus the minterm count, using a start/done handshake.
- Sits beside the POS/SOP expression modules on the lab board and bench, so each expression can be characterised in hardware.

Parameters:
- N_INPUTS, 4, number of FUT inputs. Legal range 1..6. Table depth is 2^N_INPUTS.
- SETTLE_CYCLES, 1, cycles each vector is held before `f_in` is sampled. Legal range ≥1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a scan; accepted only in IDLE.
- f_in  input  1  FUT output.
- vars_out  output  N_INPUTS  vector driven to the FUT. MSB = A, LSB = last variable (for N=4: {A,B,C,D}).
- busy  output  1  high from the cycle after start is accepted until the cycle done is asserted.
- done  output  1  one-cycle pulse when the scan is complete.
- table_out  output  2^N_INPUTS  bit i = f_in sampled with vars_out == i.
- ones_count  output  N_INPUTS+1  number of 1 bits in table_out (minterm count).

Behaviour:
- Reset is asynchronous and active-low (rst_n).
  - Asserting rst_n = 0 forces all of the following regardless of clk: state = IDLE, vars_out = 0, busy = 0, done = 0, table_out = 0, ones_count = 0, and the internal index and settle counter = 0.
  - Reset mid-scan aborts the scan. Partial results are discarded (zeroed).
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start = 1 → idx = 0, vars_out = 0, table_out = 0, ones_count = 0, settle counter = SETTLE_CYCLES, busy = 1, go to SETTLE.
  - start = 0 → hold all outputs.
- SETTLE:
  - vars_out = idx. The state lasts exactly SETTLE_CYCLES cycles (counter decrements each cycle).
  - Leave for SAMPLE when the counter reaches 1.
- SAMPLE (one cycle):
  - table_out[idx] <= f_in; ones_count <= ones_count + f_in.
  - If idx == 2^N_INPUTS − 1 → go to DONE.
  - Otherwise idx <= idx + 1, vars_out follows, counter reloads to SETTLE_CYCLES, go to SETTLE.
- DONE (one cycle): done = 1, busy = 0, return to IDLE.
- Wrap-around: idx never wraps. The last index terminates the scan, and vars_out holds 2^N_INPUTS − 1 after completion until the next start.
- Latency:
  - Each vector takes SETTLE_CYCLES + 1 cycles.
  - With start sampled high at edge k, done is high after edge k + 2^N_INPUTS·(SETTLE_CYCLES + 1) + 1.
  - For the defaults this is k + 33.
- start handling:
  - Ignored while busy or in DONE; no queuing.
  - start held high continuously → a new scan begins in the first IDLE cycle after DONE. Results are cleared at that acceptance, not earlier.
- Results stability: table_out and ones_count are stable and valid from the done cycle until the next accepted start.
- f_in is treated as synchronous to clk. The FUT is combinational, and the SETTLE_CYCLES ≥ 1 window covers its propagation delay.
- Width rules:
  - ones_count is sized to hold 2^N_INPUTS without overflow.
  - idx is N_INPUTS bits.
  - The compare to the last index uses the full idx width.

Optional Feature:
- Macro: TT_COMPARE_EN.
- When defined, the following ports are added:
  - input expected_tt (2^N_INPUTS): golden table, sampled at start acceptance.
  - output match (1): valid in the done cycle and held until the next start. 1 iff table_out == expected_tt.
  - output mismatch_mask (2^N_INPUTS): table_out XOR expected_tt, held identically.
  - Reset clears match and mismatch_mask to 0.
- When not defined, these ports and their logic do not exist and the behaviour above is unchanged.

Test Plan:
- Bench FUT f = 0, start pulse → done at k+33, table_out = 0x0000, ones_count = 0, busy high for exactly 32 cycles.
- FUT f = vars_out[3] (variable A) → table_out = 0xFF00, ones_count = 8. Check vars_out steps 0..15, each held 2 cycles.
- FUT f = XOR of all inputs, SETTLE_CYCLES = 3 → table_out = 0x6996, ones_count = 8, done at k + 16·4 + 1 = k+65.
- FUT f = 1, start re-pulsed while busy at cycles k+5 and k+20 → both ignored, single done at k+33, table_out = 0xFFFF, ones_count = 16. Then start held high → second scan begins the cycle after done, with table_out cleared to 0 at acceptance.
- Reset asserted asynchronously between edges during a scan at idx = 7 → all outputs 0 immediately. After release, a start completes a full clean scan with no residue.
- TT_COMPARE_EN defined, FUT = XOR:
  - expected_tt = 0x6996 → match = 1, mismatch_mask = 0x0000.
  - expected_tt = 0x6997 → match = 0, mismatch_mask = 0x0001.
